// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: STOP/RUN/CLEAR FSM driving a cs:s:m:h counter chain.
// Optional lap-hold display freeze is enabled with `define STOPWATCH_LAP_EN.
module stopwatch_ctrl #(
    parameter int MSEC_MOD = 100,
    parameter int HOUR_MOD = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_tick,
    input  logic       i_run_stop,
    input  logic       i_clear,
`ifdef STOPWATCH_LAP_EN
    input  logic       i_lap,
    output logic       o_lap_hold,
`endif
    output logic [6:0] o_msec,
    output logic [5:0] o_sec,
    output logic [5:0] o_min,
    output logic [4:0] o_hour,
    output logic       o_running
);

    // state    | meaning
    // ST_STOP  | counters hold, ticks discarded
    // ST_RUN   | counters advance on each tick
    // ST_CLEAR | one-cycle zeroing, then back to STOP
    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    localparam logic [6:0] MSEC_MAX = 7'(MSEC_MOD - 1);
    localparam logic [4:0] HOUR_MAX = 5'(HOUR_MOD - 1);

    state_t     state_q, state_d;
    logic       running_q, running_d;
    logic [6:0] msec_q, msec_d;
    logic [5:0] sec_q, sec_d;
    logic [5:0] min_q, min_d;
    logic [4:0] hour_q, hour_d;
    logic       zero_req;
    logic       count_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_STOP;
            running_q <= 1'b0;
            msec_q    <= '0;
            sec_q     <= '0;
            min_q     <= '0;
            hour_q    <= '0;
        end else begin
            state_q   <= state_d;
            running_q <= running_d;
            msec_q    <= msec_d;
            sec_q     <= sec_d;
            min_q     <= min_d;
            hour_q    <= hour_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_STOP: begin
                if (i_clear)
                    state_d = ST_CLEAR;
                else if (i_run_stop)
                    state_d = ST_RUN;
            end
            ST_RUN: begin
                if (i_run_stop)
                    state_d = ST_STOP;
            end
            ST_CLEAR: state_d = ST_STOP;
            default:  state_d = ST_STOP;
        endcase
        running_d = (state_d == ST_RUN);
    end

    // Zero on the edge entering CLEAR so the CLEAR cycle already shows 0.
    assign zero_req = ((state_q == ST_STOP) && i_clear) || (state_q == ST_CLEAR);
    assign count_en = (state_q == ST_RUN) && i_tick;

    always_comb begin
        msec_d = msec_q;
        sec_d  = sec_q;
        min_d  = min_q;
        hour_d = hour_q;
        if (zero_req) begin
            msec_d = '0;
            sec_d  = '0;
            min_d  = '0;
            hour_d = '0;
        end else if (count_en) begin
            if (msec_q == MSEC_MAX) begin
                msec_d = '0;
                if (sec_q == 6'd59) begin
                    sec_d = '0;
                    if (min_q == 6'd59) begin
                        min_d = '0;
                        if (hour_q == HOUR_MAX)
                            hour_d = '0;
                        else
                            hour_d = hour_q + 5'd1;
                    end else begin
                        min_d = min_q + 6'd1;
                    end
                end else begin
                    sec_d = sec_q + 6'd1;
                end
            end else begin
                msec_d = msec_q + 7'd1;
            end
        end
    end

    assign o_running = running_q;

`ifdef STOPWATCH_LAP_EN
    logic       hold_q, hold_d;
    logic [6:0] lap_msec_q, lap_msec_d;
    logic [5:0] lap_sec_q, lap_sec_d;
    logic [5:0] lap_min_q, lap_min_d;
    logic [4:0] lap_hour_q, lap_hour_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q     <= 1'b0;
            lap_msec_q <= '0;
            lap_sec_q  <= '0;
            lap_min_q  <= '0;
            lap_hour_q <= '0;
        end else begin
            hold_q     <= hold_d;
            lap_msec_q <= lap_msec_d;
            lap_sec_q  <= lap_sec_d;
            lap_min_q  <= lap_min_d;
            lap_hour_q <= lap_hour_d;
        end
    end

    // Snapshot takes the pre-tick counter value visible on the setting edge.
    always_comb begin
        hold_d     = hold_q;
        lap_msec_d = lap_msec_q;
        lap_sec_d  = lap_sec_q;
        lap_min_d  = lap_min_q;
        lap_hour_d = lap_hour_q;
        if (zero_req) begin
            hold_d = 1'b0;
        end else if ((state_q == ST_RUN) && i_lap) begin
            hold_d = ~hold_q;
            if (!hold_q) begin
                lap_msec_d = msec_q;
                lap_sec_d  = sec_q;
                lap_min_d  = min_q;
                lap_hour_d = hour_q;
            end
        end
    end

    assign o_lap_hold = hold_q;
    assign o_msec     = hold_q ? lap_msec_q : msec_q;
    assign o_sec      = hold_q ? lap_sec_q  : sec_q;
    assign o_min      = hold_q ? lap_min_q  : min_q;
    assign o_hour     = hold_q ? lap_hour_q : hour_q;
`else
    assign o_msec = msec_q;
    assign o_sec  = sec_q;
    assign o_min  = min_q;
    assign o_hour = hour_q;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: elapsed-tick model compared every cycle plus literal checkpoints.
// A second instance with small moduli exercises the full hour wrap in few cycles.
module tb_stopwatch_ctrl;

    localparam int unsigned MM_A = 100;
    localparam int unsigned HM_A = 24;
    localparam int unsigned MM_B = 2;
    localparam int unsigned HM_B = 2;
    localparam int unsigned PERIOD_A = MM_A * 3600 * HM_A;
    localparam int unsigned PERIOD_B = MM_B * 3600 * HM_B;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick_a = 1'b0, rs_a = 1'b0, clr_a = 1'b0, lap = 1'b0;
    logic tick_b = 1'b0, rs_b = 1'b0, clr_b = 1'b0;

    logic [6:0] a_msec, b_msec;
    logic [5:0] a_sec, a_min, b_sec, b_min;
    logic [4:0] a_hour, b_hour;
    logic       a_running, b_running;
`ifdef STOPWATCH_LAP_EN
    logic       a_lap_hold;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    stopwatch_ctrl dut_a (
        .clk       (clk),
        .rst       (rst),
        .i_tick    (tick_a),
        .i_run_stop(rs_a),
        .i_clear   (clr_a),
`ifdef STOPWATCH_LAP_EN
        .i_lap     (lap),
        .o_lap_hold(a_lap_hold),
`endif
        .o_msec    (a_msec),
        .o_sec     (a_sec),
        .o_min     (a_min),
        .o_hour    (a_hour),
        .o_running (a_running)
    );

    stopwatch_ctrl #(.MSEC_MOD(MM_B), .HOUR_MOD(HM_B)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .i_tick    (tick_b),
        .i_run_stop(rs_b),
        .i_clear   (clr_b),
`ifdef STOPWATCH_LAP_EN
        .i_lap     (1'b0),
        .o_lap_hold(),
`endif
        .o_msec    (b_msec),
        .o_sec     (b_sec),
        .o_min     (b_min),
        .o_hour    (b_hour),
        .o_running (b_running)
    );

    // Display value {hour,min,sec,cs} derived from an elapsed tick count.
    function automatic logic [23:0] disp(input int unsigned t, input int unsigned mm);
        int unsigned h, m, s, c;
        c = t % mm;
        s = (t / mm) % 60;
        m = (t / (mm * 60)) % 60;
        h = t / (mm * 3600);
        return {5'(h), 6'(m), 6'(s), 7'(c)};
    endfunction

    function automatic logic [23:0] hms(input int h, input int m, input int s, input int c);
        return {5'(h), 6'(m), 6'(s), 7'(c)};
    endfunction

    // Model: elapsed ticks, a run flag and a pending-clear flag.
    int unsigned ma_total, ma_cap, mb_total;
    bit          ma_run, ma_clr, ma_hold, mb_run;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ma_total <= 0; ma_run <= 0; ma_clr <= 0; ma_hold <= 0; ma_cap <= 0;
        end else if (ma_clr) begin
            ma_clr <= 0; ma_total <= 0; ma_hold <= 0;
        end else if (ma_run) begin
            if (tick_a) ma_total <= (ma_total + 1) % PERIOD_A;
            if (rs_a) ma_run <= 0;
            if (lap) begin
                ma_hold <= !ma_hold;
                if (!ma_hold) ma_cap <= ma_total;
            end
        end else if (clr_a) begin
            ma_clr <= 1; ma_total <= 0; ma_hold <= 0;
        end else if (rs_a) begin
            ma_run <= 1;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mb_total <= 0; mb_run <= 0;
        end else if (mb_run) begin
            if (tick_b) mb_total <= (mb_total + 1) % PERIOD_B;
            if (rs_b) mb_run <= 0;
        end else if (rs_b) begin
            mb_run <= 1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            logic [24:0] exp_a, exp_b;
`ifdef STOPWATCH_LAP_EN
            exp_a = {ma_run, disp(ma_hold ? ma_cap : ma_total, MM_A)};
            n_cmp++;
            if (a_lap_hold !== ma_hold) begin
                n_bad++;
                $display("FAIL model_lap_hold t=%0t got=%b exp=%b", $time, a_lap_hold, ma_hold);
            end
`else
            exp_a = {ma_run, disp(ma_total, MM_A)};
`endif
            exp_b = {mb_run, disp(mb_total, MM_B)};
            n_cmp++;
            if ({a_running, a_hour, a_min, a_sec, a_msec} !== exp_a) begin
                n_bad++;
                $display("FAIL model_a t=%0t got run=%b %0d:%0d:%0d:%0d exp run=%b %0d:%0d:%0d:%0d",
                         $time, a_running, a_hour, a_min, a_sec, a_msec,
                         exp_a[24], exp_a[23:19], exp_a[18:13], exp_a[12:7], exp_a[6:0]);
            end
            n_cmp++;
            if ({b_running, b_hour, b_min, b_sec, b_msec} !== exp_b) begin
                n_bad++;
                $display("FAIL model_b t=%0t got run=%b %0d:%0d:%0d:%0d exp run=%b %0d:%0d:%0d:%0d",
                         $time, b_running, b_hour, b_min, b_sec, b_msec,
                         exp_b[24], exp_b[23:19], exp_b[18:13], exp_b[12:7], exp_b[6:0]);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", name, act, exp);
        end
    endtask

    task automatic ticks_a(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) tick_a = 1'b1;
        end
        @(negedge clk) tick_a = 1'b0;
    endtask

    task automatic ticks_b(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) tick_b = 1'b1;
        end
        @(negedge clk) tick_b = 1'b0;
    endtask

    task automatic pulse_a(input logic rs, input logic clr, input logic tk, input logic lp);
        @(negedge clk);
        rs_a = rs; clr_a = clr; tick_a = tk; lap = lp;
        @(negedge clk);
        rs_a = 1'b0; clr_a = 1'b0; tick_a = 1'b0; lap = 1'b0;
    endtask

    function automatic logic [31:0] a_time();
        return {8'd0, a_hour, a_min, a_sec, a_msec};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_time", a_time(), 32'(hms(0, 0, 0, 0)));
        chk("reset_running", 32'(a_running), 32'd0);
        rst = 1'b0;

        // Idle ticks before any run pulse are ignored
        ticks_a(4);
        chk("no_start_without_pulse", a_time(), 32'(hms(0, 0, 0, 0)));

        pulse_a(1'b1, 1'b0, 1'b0, 1'b0);
        ticks_a(150);
        chk("run_150_time", a_time(), 32'(hms(0, 0, 1, 50)));
        chk("run_150_running", 32'(a_running), 32'd1);

        ticks_a(5849);
        chk("at_59_99", a_time(), 32'(hms(0, 0, 59, 99)));
        ticks_a(1);
        chk("carry_to_min", a_time(), 32'(hms(0, 1, 0, 0)));

        pulse_a(1'b0, 1'b1, 1'b1, 1'b0);
        chk("clear_ignored_in_run", a_time(), 32'(hms(0, 1, 0, 1)));
        chk("still_running", 32'(a_running), 32'd1);

        pulse_a(1'b1, 1'b0, 1'b1, 1'b0);
        chk("stop_tick_counted", a_time(), 32'(hms(0, 1, 0, 2)));
        chk("stopped", 32'(a_running), 32'd0);
        ticks_a(20);
        chk("stop_holds", a_time(), 32'(hms(0, 1, 0, 2)));

        pulse_a(1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("cleared", a_time(), 32'(hms(0, 0, 0, 0)));

        pulse_a(1'b1, 1'b0, 1'b0, 1'b0);
        ticks_a(500);
        pulse_a(1'b1, 1'b0, 1'b0, 1'b0);
        chk("stop_at_5s", a_time(), 32'(hms(0, 0, 5, 0)));

        pulse_a(1'b1, 1'b1, 1'b0, 1'b0);
        chk("clear_cycle_zero", a_time(), 32'(hms(0, 0, 0, 0)));
        chk("clear_cycle_not_running", 32'(a_running), 32'd0);
        @(negedge clk);
        ticks_a(3);
        chk("after_clear_in_stop", a_time(), 32'(hms(0, 0, 0, 0)));
        chk("after_clear_running", 32'(a_running), 32'd0);

        pulse_a(1'b1, 1'b0, 1'b0, 1'b0);
        ticks_a(1037);
        chk("at_10_37", a_time(), 32'(hms(0, 0, 10, 37)));
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_time", a_time(), 32'(hms(0, 0, 0, 0)));
        chk("async_rst_running", 32'(a_running), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ticks_a(5);
        chk("post_rst_needs_pulse", a_time(), 32'(hms(0, 0, 0, 0)));

`ifdef STOPWATCH_LAP_EN
        pulse_a(1'b1, 1'b0, 1'b0, 1'b0);
        ticks_a(200);
        pulse_a(1'b0, 1'b0, 1'b0, 1'b1);
        chk("lap_set_hold", 32'(a_lap_hold), 32'd1);
        ticks_a(100);
        chk("lap_frozen", a_time(), 32'(hms(0, 0, 2, 0)));
        pulse_a(1'b0, 1'b0, 1'b0, 1'b1);
        chk("lap_release", a_time(), 32'(hms(0, 0, 3, 0)));
        chk("lap_release_flag", 32'(a_lap_hold), 32'd0);
        pulse_a(1'b1, 1'b0, 1'b0, 1'b0);
`endif

        // Small-modulus instance: full-range wrap of all four fields
        @(negedge clk) rs_b = 1'b1;
        @(negedge clk) rs_b = 1'b0;
        ticks_b(120);
        chk("b_one_minute", {8'd0, b_hour, b_min, b_sec, b_msec}, 32'(hms(0, 1, 0, 0)));
        ticks_b(int'(PERIOD_B) - 121);
        chk("b_at_max", {8'd0, b_hour, b_min, b_sec, b_msec}, 32'(hms(1, 59, 59, 1)));
        ticks_b(1);
        chk("b_full_wrap", {8'd0, b_hour, b_min, b_sec, b_msec}, 32'(hms(0, 0, 0, 0)));
        chk("b_running", 32'(b_running), 32'd1);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
